// File: rtl/fp_mul_arbiter.sv
// Two-requester arbiter in front of a shared combinational FP16 multiplier.
// Accepts one operand pair, issues it for one cycle, then holds the
// registered product until the consumer takes it. Also keeps per-requester
// completion counts and a sticky NaN/Inf exception flag.
module fp_mul_arbiter #(
    parameter int unsigned PRIO_FIXED = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req1_ready,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    input  logic [15:0] mul_p,
    input  logic [5:0]  mul_flags,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [15:0] rsp_p,
    output logic [5:0]  rsp_flags,
    input  logic        rsp_ready,
    output logic [15:0] cnt0,
    output logic [15:0] cnt1,
    output logic        exc
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t      state, state_nx;
    logic        grant;
    logic        last_grant;
    logic        id;
    logic        accept;
    logic [15:0] op_a, op_b;

    assign mul_a = op_a;
    assign mul_b = op_b;

    // Grant selection: lone requester wins; on contention use round-robin or fixed priority
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (PRIO_FIXED != 0) ? 1'b0 : ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // Next-state and ready outputs; readys are gated by reset so none leaks out while held
    always_comb begin
        state_nx   = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = rst & req0_valid & ~grant;
                req1_ready = rst & req1_valid & grant;
                accept     = rst & ((req0_valid & ~grant) | (req1_valid & grant));
                if (accept) begin
                    state_nx = ISSUE;
                end
            end
            ISSUE: state_nx = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Datapath: operand latch, response capture, counters and sticky exception
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            id         <= 1'b0;
            op_a       <= '0;
            op_b       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_p      <= '0;
            rsp_flags  <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            exc        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_a <= grant ? req1_a : req0_a;
                        op_b <= grant ? req1_b : req0_b;
                        id   <= grant;
                    end
                end
                ISSUE: begin
                    rsp_p     <= mul_p;
                    rsp_flags <= mul_flags;
                    rsp_valid <= 1'b1;
                    rsp_id    <= id;
                    if (|mul_flags[5:3]) begin
                        exc <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid  <= 1'b0;
                        last_grant <= id;
                        if (id) begin
                            cnt1 <= cnt1 + 16'd1;
                        end else begin
                            cnt0 <= cnt0 + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
